// File: rtl/pipmem_rv32_pkg.sv
// pipmem_rv32_pkg: shared constants and types for the RV32I memory-access stage.
//   - one-hot decoded op encodings for the eight load/store ops
//   - FSM state encodings, oFAULT bit indices, lane-mask constants
//   - memReq_t: request fields latched when a bus transaction starts
package pipmem_rv32_pkg;

    localparam int unsigned OP_W = 10;

    localparam logic [OP_W-1:0] OP_LB  = 10'b00_0000_0001;
    localparam logic [OP_W-1:0] OP_LH  = 10'b00_0000_0010;
    localparam logic [OP_W-1:0] OP_LW  = 10'b00_0000_0100;
    localparam logic [OP_W-1:0] OP_LBU = 10'b00_0000_1000;
    localparam logic [OP_W-1:0] OP_LHU = 10'b00_0001_0000;
    localparam logic [OP_W-1:0] OP_SB  = 10'b00_0010_0000;
    localparam logic [OP_W-1:0] OP_SH  = 10'b00_0100_0000;
    localparam logic [OP_W-1:0] OP_SW  = 10'b00_1000_0000;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUS  = 1'b1;

    localparam int unsigned FAULT_TIMEOUT = 0;
    localparam int unsigned FAULT_ALIGN   = 1;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef struct packed {
        logic [OP_W-1:0] op;
        logic [1:0]      lane;
        logic [4:0]      rd;
        logic            isLoad;
    } memReq_t;

endpackage

// File: rtl/pipmem_rv32_memlane.sv
// memlane_rv32: combinational lane steering for one load/store.
//   iOP      one-hot decoded op
//   iADDRLO  byte offset within the word
//   iSTDATA  store data (low byte/half significant for SB/SH)
//   iRDWORD  word returned by the bus
//   oBE      byte enables (same mask for loads and stores)
//   oWDATA   lane-replicated store data
//   oLDDATA  selected and extended load data
//   oMISALIGN  half/word access not naturally aligned
//   oKNOWN   op is one of the eight load/store ops
module memlane_rv32
    import pipmem_rv32_pkg::*;
(
    input  logic [OP_W-1:0] iOP,
    input  logic [1:0]      iADDRLO,
    input  logic [31:0]     iSTDATA,
    input  logic [31:0]     iRDWORD,
    output logic [3:0]      oBE,
    output logic [31:0]     oWDATA,
    output logic [31:0]     oLDDATA,
    output logic            oMISALIGN,
    output logic            oKNOWN
);

    logic isLB, isLH, isLW, isLBU, isLHU, isSB, isSH, isSW;
    logic sizeByte, sizeHalf, sizeWord;
    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    assign isLB  = (iOP == OP_LB);
    assign isLH  = (iOP == OP_LH);
    assign isLW  = (iOP == OP_LW);
    assign isLBU = (iOP == OP_LBU);
    assign isLHU = (iOP == OP_LHU);
    assign isSB  = (iOP == OP_SB);
    assign isSH  = (iOP == OP_SH);
    assign isSW  = (iOP == OP_SW);

    assign sizeByte = isLB | isLBU | isSB;
    assign sizeHalf = isLH | isLHU | isSH;
    assign sizeWord = isLW | isSW;

    assign oKNOWN    = sizeByte | sizeHalf | sizeWord;
    assign oMISALIGN = (sizeHalf & iADDRLO[0]) | (sizeWord & (iADDRLO != 2'b00));

    // Byte enables and replicated write data
    always_comb begin
        oBE    = 4'b0000;
        oWDATA = iSTDATA;
        if (sizeByte) begin
            oBE    = 4'(BE_BYTE << iADDRLO);
            oWDATA = {4{iSTDATA[7:0]}};
        end else if (sizeHalf) begin
            oBE    = 4'(BE_HALF << {iADDRLO[1], 1'b0});
            oWDATA = {2{iSTDATA[15:0]}};
        end else if (sizeWord) begin
            oBE    = BE_WORD;
        end
    end

    // Byte/half lane selection from the returned word
    always_comb begin
        byteSel = iRDWORD[7:0];
        case (iADDRLO)
            2'd0:    byteSel = iRDWORD[7:0];
            2'd1:    byteSel = iRDWORD[15:8];
            2'd2:    byteSel = iRDWORD[23:16];
            default: byteSel = iRDWORD[31:24];
        endcase
    end

    assign halfSel = iADDRLO[1] ? iRDWORD[31:16] : iRDWORD[15:0];

    // Sign or zero extension
    always_comb begin
        oLDDATA = iRDWORD;
        if (isLB)       oLDDATA = {{24{byteSel[7]}}, byteSel};
        else if (isLBU) oLDDATA = {24'd0, byteSel};
        else if (isLH)  oLDDATA = {{16{halfSel[15]}}, halfSel};
        else if (isLHU) oLDDATA = {16'd0, halfSel};
    end

endmodule

// File: rtl/pipmem_rv32.sv
// pipmem_rv32: RV32I memory-access stage between execute and write-back.
//   iCLK/iRST        clock, synchronous active-high reset
//   iMEM/iRW         memory request this cycle, 1 = load
//   iMEMADDR/iMEMDATA byte address and store data
//   iDregDATA/iDregADDR execute result and destination for non-memory ops
//   iDecodedOP       one-hot decoded op
//   oSTALL           combinational hold for the execute stage
//   oBUS*/iBUS*      word-addressed request/acknowledge bus
//   oDregDATA/ADDR/WE write-back result, one-cycle enable
//   oFAULT           [1] misaligned/unknown op, [0] bus timeout (pulse)
module pipmem_rv32
    import pipmem_rv32_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic            iCLK,
    input  logic            iRST,
    input  logic            iMEM,
    input  logic            iRW,
    input  logic [31:0]     iMEMADDR,
    input  logic [31:0]     iMEMDATA,
    input  logic [31:0]     iDregDATA,
    input  logic [4:0]      iDregADDR,
    input  logic [OP_W-1:0] iDecodedOP,
    output logic            oSTALL,
    output logic            oBUSREQ,
    output logic            oBUSWE,
    output logic [29:0]     oBUSADDR,
    output logic [3:0]      oBUSBE,
    output logic [31:0]     oBUSWDATA,
    input  logic            iBUSACK,
    input  logic [31:0]     iBUSRDATA,
    output logic [31:0]     oDregDATA,
    output logic [4:0]      oDregADDR,
    output logic            oDregWE,
    output logic [1:0]      oFAULT
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [0:0]       state, stateNext;
    memReq_t          req, reqNext;
    logic [CNT_W-1:0] cnt, cntNext;

    logic        busReqNext, busWeNext;
    logic [29:0] busAddrNext;
    logic [3:0]  busBeNext;
    logic [31:0] busWdataNext;
    logic [31:0] dregDataNext;
    logic [4:0]  dregAddrNext;
    logic        dregWeNext;
    logic [1:0]  faultNext;

    logic [OP_W-1:0] laneOp;
    logic [1:0]      laneAddr;
    logic [3:0]      laneBe;
    logic [31:0]     laneWdata, laneLoad;
    logic            laneMisalign, laneKnown;
    logic            accept_c, timeout_c;

    // Lane logic sees the incoming request in IDLE and the latched one in BUS
    assign laneOp   = (state == ST_IDLE) ? iDecodedOP : req.op;
    assign laneAddr = (state == ST_IDLE) ? iMEMADDR[1:0] : req.lane;

    memlane_rv32 uLane (
        .iOP       (laneOp),
        .iADDRLO   (laneAddr),
        .iSTDATA   (iMEMDATA),
        .iRDWORD   (iBUSRDATA),
        .oBE       (laneBe),
        .oWDATA    (laneWdata),
        .oLDDATA   (laneLoad),
        .oMISALIGN (laneMisalign),
        .oKNOWN    (laneKnown)
    );

    assign accept_c  = (state == ST_IDLE) & iMEM & laneKnown & ~laneMisalign;
    assign timeout_c = (state == ST_BUS) & ~iBUSACK & (cnt == CNT_LAST);

    // Stall drops in the ack/abort cycle so execute advances exactly once
    assign oSTALL = ~iRST & (accept_c | ((state == ST_BUS) & ~iBUSACK & ~timeout_c));

    // State register and output registers
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state     <= ST_IDLE;
            req       <= '0;
            cnt       <= '0;
            oBUSREQ   <= 1'b0;
            oBUSWE    <= 1'b0;
            oBUSADDR  <= '0;
            oBUSBE    <= '0;
            oBUSWDATA <= '0;
            oDregDATA <= '0;
            oDregADDR <= '0;
            oDregWE   <= 1'b0;
            oFAULT    <= '0;
        end else begin
            state     <= stateNext;
            req       <= reqNext;
            cnt       <= cntNext;
            oBUSREQ   <= busReqNext;
            oBUSWE    <= busWeNext;
            oBUSADDR  <= busAddrNext;
            oBUSBE    <= busBeNext;
            oBUSWDATA <= busWdataNext;
            oDregDATA <= dregDataNext;
            oDregADDR <= dregAddrNext;
            oDregWE   <= dregWeNext;
            oFAULT    <= faultNext;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        stateNext    = state;
        reqNext      = req;
        cntNext      = cnt;
        busReqNext   = oBUSREQ;
        busWeNext    = oBUSWE;
        busAddrNext  = oBUSADDR;
        busBeNext    = oBUSBE;
        busWdataNext = oBUSWDATA;
        dregDataNext = oDregDATA;
        dregAddrNext = oDregADDR;
        dregWeNext   = 1'b0;
        faultNext    = 2'b00;

        case (state)
            ST_IDLE: begin
                if (!iMEM) begin
                    dregDataNext = iDregDATA;
                    dregAddrNext = iDregADDR;
                    dregWeNext   = (iDregADDR != 5'd0);
                end else if (accept_c) begin
                    reqNext.op     = iDecodedOP;
                    reqNext.lane   = iMEMADDR[1:0];
                    reqNext.rd     = iDregADDR;
                    reqNext.isLoad = iRW;
                    cntNext        = '0;
                    busReqNext     = 1'b1;
                    busWeNext      = ~iRW;
                    busAddrNext    = iMEMADDR[31:2];
                    busBeNext      = laneBe;
                    busWdataNext   = laneWdata;
                    stateNext      = ST_BUS;
                end else begin
                    faultNext[FAULT_ALIGN] = 1'b1;
                end
            end
            default: begin
                if (iBUSACK || timeout_c) begin
                    busReqNext   = 1'b0;
                    busWeNext    = 1'b0;
                    busAddrNext  = '0;
                    busBeNext    = '0;
                    busWdataNext = '0;
                    stateNext    = ST_IDLE;
                    if (iBUSACK) begin
                        if (req.isLoad) begin
                            dregDataNext = laneLoad;
                            dregAddrNext = req.rd;
                            dregWeNext   = (req.rd != 5'd0);
                        end
                    end else begin
                        faultNext[FAULT_TIMEOUT] = 1'b1;
                    end
                end else begin
                    cntNext = cnt + CNT_W'(1);
                end
            end
        endcase
    end

endmodule

// File: tb/tb_pipmem_rv32.sv
// tb_pipmem_rv32: randomized scoreboard bench for pipmem_rv32 with a
// byte-array reference model and a bus responder holding a word memory.
module tb_pipmem_rv32;
    import pipmem_rv32_pkg::*;

    localparam int TO    = 4;
    localparam int NEVER = 1000;

    logic        iCLK, iRST, iMEM, iRW, iBUSACK;
    logic [31:0] iMEMADDR, iMEMDATA, iDregDATA, iBUSRDATA;
    logic [4:0]  iDregADDR;
    logic [9:0]  iDecodedOP;
    logic        oSTALL, oBUSREQ, oBUSWE, oDregWE;
    logic [29:0] oBUSADDR;
    logic [3:0]  oBUSBE;
    logic [31:0] oBUSWDATA, oDregDATA;
    logic [4:0]  oDregADDR;
    logic [1:0]  oFAULT;

    pipmem_rv32 #(.TIMEOUT(TO)) dut (
        .iCLK(iCLK), .iRST(iRST), .iMEM(iMEM), .iRW(iRW),
        .iMEMADDR(iMEMADDR), .iMEMDATA(iMEMDATA),
        .iDregDATA(iDregDATA), .iDregADDR(iDregADDR), .iDecodedOP(iDecodedOP),
        .oSTALL(oSTALL), .oBUSREQ(oBUSREQ), .oBUSWE(oBUSWE), .oBUSADDR(oBUSADDR),
        .oBUSBE(oBUSBE), .oBUSWDATA(oBUSWDATA), .iBUSACK(iBUSACK), .iBUSRDATA(iBUSRDATA),
        .oDregDATA(oDregDATA), .oDregADDR(oDregADDR), .oDregWE(oDregWE), .oFAULT(oFAULT)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    int nChecks = 0;
    int nFails  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic failNow(input string name);
        nChecks++;
        nFails++;
        $display("FAIL %s: unexpected event at %0t", name, $time);
    endtask

    typedef struct { logic [4:0] rd; logic [31:0] data; } wb_t;
    typedef struct { logic we; logic [29:0] addr; logic [3:0] be; logic [31:0] wdata; int len; } bus_t;

    wb_t        expWb[$];
    bus_t       expBus[$];
    logic [1:0] expFault[$];

    logic [31:0] busMem  [0:255];
    logic [7:0]  refByte [0:1023];
    int          respWait = NEVER;

    task automatic setWord(input int w, input logic [31:0] v);
        busMem[w] = v;
        for (int i = 0; i < 4; i++) refByte[4*w+i] = 8'((v >> (8*i)) & 32'hFF);
    endtask

    // Bus responder: acks after respWait cycles of request, applies writes
    initial begin
        iBUSACK = 1'b0;
        iBUSRDATA = '0;
        forever begin
            @(posedge iCLK);
            #1;
            iBUSACK = 1'b0;
            iBUSRDATA = $urandom;
            if (oBUSREQ && !iRST && respWait != NEVER) begin
                if (respWait == 0) begin
                    iBUSACK = 1'b1;
                    iBUSRDATA = busMem[oBUSADDR[7:0]];
                    if (oBUSWE)
                        for (int b = 0; b < 4; b++)
                            if (oBUSBE[b]) busMem[oBUSADDR[7:0]][8*b +: 8] = oBUSWDATA[8*b +: 8];
                    respWait = NEVER;
                end else begin
                    respWait--;
                end
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents something
    bit   prevReq = 1'b0;
    int   reqLen = 0;
    bus_t cur;
    initial begin
        cur = '{we: 1'b0, addr: '0, be: '0, wdata: '0, len: -1};
        forever begin
            @(negedge iCLK);
            if (iRST) begin
                prevReq = 1'b0;
                reqLen = 0;
            end else begin
                if (oBUSREQ && !prevReq) begin
                    if (expBus.size() == 0) failNow("unexpectedBusReq");
                    else begin
                        cur = expBus.pop_front();
                        reqLen = 0;
                        check("busWE", 32'(oBUSWE), 32'(cur.we));
                        check("busWDATA", oBUSWDATA, cur.wdata);
                    end
                end
                if (oBUSREQ) begin
                    reqLen++;
                    check("busADDR", 32'(oBUSADDR), 32'(cur.addr));
                    check("busBE", 32'(oBUSBE), 32'(cur.be));
                end
                if (!oBUSREQ && prevReq && cur.len >= 0) check("busReqLen", reqLen, cur.len);
                if (oDregWE) begin
                    if (expWb.size() == 0) failNow("unexpectedDregWE");
                    else begin
                        wb_t w;
                        w = expWb.pop_front();
                        check("dregADDR", 32'(oDregADDR), 32'(w.rd));
                        check("dregDATA", oDregDATA, w.data);
                    end
                end
                if (oFAULT != 2'b00) begin
                    if (expFault.size() == 0) failNow("unexpectedFault");
                    else check("fault", 32'(oFAULT), 32'(expFault.pop_front()));
                end
                prevReq = oBUSREQ;
            end
        end
    end

    // Issue one op, build its expected outcome from the reference model, wait for it to leave execute
    task automatic doOp(input bit mem, input logic [9:0] op, input logic [31:0] addr,
                        input logic [31:0] data, input logic [4:0] rd, input int waitCycles);
        bit isLoad, isStore, timedOut;
        int size, expStall, stalls, lane;
        logic [31:0] v, h;
        isLoad  = (op == OP_LB) || (op == OP_LH) || (op == OP_LW) || (op == OP_LBU) || (op == OP_LHU);
        isStore = (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
        size = (op == OP_LB || op == OP_LBU || op == OP_SB) ? 1 :
               (op == OP_LH || op == OP_LHU || op == OP_SH) ? 2 : 4;
        timedOut = (waitCycles >= TO);
        expStall = 0;
        if (!mem) begin
            if (rd != 0) expWb.push_back('{rd: rd, data: data});
        end else if (!(isLoad || isStore) || (addr % size) != 0) begin
            expFault.push_back(2'b10);
        end else begin
            bus_t e;
            lane = int'(addr % 4);
            e.we    = isStore;
            e.addr  = 30'(addr / 4);
            e.be    = 4'(((1 << size) - 1) << lane);
            e.wdata = (size == 1) ? (data & 32'hFF) * 32'h01010101 :
                      (size == 2) ? (data & 32'hFFFF) * 32'h00010001 : data;
            e.len   = timedOut ? TO : waitCycles + 1;
            expBus.push_back(e);
            if (timedOut) begin
                expFault.push_back(2'b01);
                expStall = TO;
            end else begin
                expStall = waitCycles + 1;
                if (isLoad) begin
                    if (size == 1) begin
                        v = 32'(refByte[addr]);
                        if (op == OP_LB && v >= 128) v = v + 32'hFFFFFF00;
                    end else if (size == 2) begin
                        h = 32'(refByte[addr]) + 256 * 32'(refByte[addr+1]);
                        v = (op == OP_LH && h >= 32768) ? h + 32'hFFFF0000 : h;
                    end else begin
                        v = 0;
                        for (int i = 3; i >= 0; i--) v = v * 256 + 32'(refByte[addr+i]);
                    end
                    if (rd != 0) expWb.push_back('{rd: rd, data: v});
                end else begin
                    for (int i = 0; i < size; i++) refByte[addr+i] = 8'((data >> (8*i)) & 32'hFF);
                end
            end
            respWait = timedOut ? NEVER : waitCycles;
        end
        iMEM       = mem;
        iRW        = (isLoad || isStore) ? isLoad : 1'($urandom);
        iDecodedOP = op;
        iMEMADDR   = addr;
        iMEMDATA   = data;
        iDregADDR  = rd;
        iDregDATA  = mem ? $urandom : data;
        stalls = 0;
        for (int c = 0; ; c++) begin
            @(negedge iCLK);
            if (!oSTALL) break;
            stalls++;
            if (c > 50) begin
                failNow("stallTimeout");
                break;
            end
        end
        check("stallCycles", stalls, expStall);
        @(posedge iCLK);
        #1;
        iMEM = 1'b0;
        iDecodedOP = '0;
        iDregADDR = '0;
    endtask

    function automatic logic [9:0] pickOp(input int k);
        logic [9:0] ops [0:7];
        ops = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};
        return ops[k];
    endfunction

    initial begin
        iRST = 1'b1; iMEM = 1'b0; iRW = 1'b0; iMEMADDR = '0; iMEMDATA = '0;
        iDregDATA = '0; iDregADDR = '0; iDecodedOP = '0;
        for (int w = 0; w < 256; w++) setWord(w, $urandom);
        repeat (3) @(posedge iCLK);
        @(negedge iCLK);
        check("rstBUSREQ", 32'(oBUSREQ), 0);
        check("rstDregWE", 32'(oDregWE), 0);
        check("rstDregDATA", oDregDATA, 0);
        check("rstFAULT", 32'(oFAULT), 0);
        check("rstSTALL", 32'(oSTALL), 0);
        check("rstBUSBE", 32'(oBUSBE), 0);
        @(posedge iCLK);
        #1;
        iRST = 1'b0;

        // Directed cases
        doOp(1'b0, 10'h300, 32'h0, 32'h12345678, 5'd5, 0);
        doOp(1'b0, 10'h300, 32'h0, 32'hDEADBEEF, 5'd0, 0);
        setWord(32'h40, 32'h80FF7F01);
        doOp(1'b1, OP_LB,  32'h103, 32'h0, 5'd3, 2);
        doOp(1'b1, OP_LBU, 32'h103, 32'h0, 5'd4, 0);
        doOp(1'b1, OP_SH,  32'h202, 32'hFFFFBEEF, 5'd6, 0);
        doOp(1'b1, OP_LW,  32'h200, 32'h0, 5'd7, 1);
        doOp(1'b1, OP_LW,  32'h101, 32'h0, 5'd8, 0);
        doOp(1'b1, OP_SW,  32'h300, 32'h11223344, 5'd0, NEVER);
        doOp(1'b1, OP_LW,  32'h300, 32'h0, 5'd9, 3);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            int kind, w;
            logic [31:0] a;
            logic [9:0]  op;
            kind = $urandom_range(0, 10);
            a = $urandom_range(0, 1020);
            if ($urandom_range(0, 3) != 0) a = a & ~32'h3;
            w = ($urandom_range(0, 5) == 0) ? NEVER : $urandom_range(0, TO - 1);
            if (kind < 8) begin
                op = pickOp(kind);
                doOp(1'b1, op, a, $urandom, 5'($urandom), w);
            end else if (kind == 9) begin
                op = ($urandom_range(0, 1) != 0) ? 10'h200 : (OP_LB | OP_SB);
                doOp(1'b1, op, a, $urandom, 5'($urandom), w);
            end else begin
                doOp(1'b0, 10'h100, 32'h0, $urandom, 5'($urandom), 0);
            end
        end

        // Reset while a load is outstanding
        expBus.push_back('{we: 1'b0, addr: 30'h4, be: 4'hF, wdata: 32'h0, len: -1});
        respWait = NEVER;
        iMEM = 1'b1; iRW = 1'b1; iDecodedOP = OP_LW; iMEMADDR = 32'h10; iMEMDATA = '0; iDregADDR = 5'd7;
        @(posedge iCLK);
        #1;
        iMEM = 1'b0; iDregADDR = 5'd0;
        check("busReqBeforeRst", 32'(oBUSREQ), 1);
        @(posedge iCLK);
        #1;
        iRST = 1'b1;
        @(posedge iCLK);
        #1;
        check("rstMidBusREQ", 32'(oBUSREQ), 0);
        check("rstMidBusBE", 32'(oBUSBE), 0);
        check("rstMidDregWE", 32'(oDregWE), 0);
        iRST = 1'b0;
        @(negedge iCLK);
        check("postRstSTALL", 32'(oSTALL), 0);
        check("postRstREQ", 32'(oBUSREQ), 0);
        @(posedge iCLK);
        #1;
        setWord(0, 32'hCAFEF00D);
        doOp(1'b1, OP_LW, 32'h0, 32'h0, 5'd9, 1);

        repeat (8) @(posedge iCLK);
        check("wbQueueEmpty", expWb.size(), 0);
        check("busQueueEmpty", expBus.size(), 0);
        check("faultQueueEmpty", expFault.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
